// File: rtl/counter_mode_sequencer_pkg.sv
// Shared definitions for the counter mode sequencer and the counter benches:
// FSM state encoding and the universal-counter mode select constants.
package counter_mode_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  function automatic logic [1:0] run_mode(input logic dir);
    return dir ? MODE_DOWN : MODE_UP;
  endfunction

endpackage

// File: rtl/counter_mode_sequencer_step.sv
// Step down-counter for the sequencer: parallel load, decrement toward zero,
// and flags for "no steps left" and "on the final step".
module step_counter #(
  parameter int STEPW = 8
) (
  input  logic             CLOCK,
  input  logic             Reset,
  input  logic             Load,
  input  logic [STEPW-1:0] LoadValue,
  input  logic             Dec,
  output logic             Zero,
  output logic             Last
);

  logic [STEPW-1:0] count;

  // Decrement stops at zero so a stray Dec can never wrap the count.
  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      count <= '0;
    end else if (Load) begin
      count <= LoadValue;
    end else if (Dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign Zero = (count == '0);
  assign Last = (count == STEPW'(1));

endmodule

// File: rtl/counter_mode_sequencer.sv
// Drives a universal counter's mode select and load data through a
// load / run / done command sequence, counting terminal-count events.
module counter_mode_sequencer
  import counter_mode_sequencer_pkg::*;
#(
  parameter int LENGTH = 4,
  parameter int STEPW  = 8
) (
  input  logic              CLOCK,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Dir,
  input  logic              LoadEn,
  input  logic [LENGTH-1:0] LoadValue,
  input  logic [STEPW-1:0]  Steps,
  input  logic              Abort,
  input  logic              TerminalCount,
  output logic              S1,
  output logic              S0,
  output logic [LENGTH-1:0] P,
  output logic              Busy,
  output logic              Done,
  output logic              Aborted,
  output logic [STEPW-1:0]  WrapCount
);

  localparam logic [STEPW-1:0] WRAP_MAX = '1;

  state_t            state;
  state_t            stateNext;
  logic              dirReg;
  logic              dirNext;
  logic [1:0]        modeNext;
  logic [LENGTH-1:0] pNext;
  logic              busyNext;
  logic              doneNext;
  logic              abortedNext;
  logic [STEPW-1:0]  wrapNext;
  logic              accept;
  logic              stepZero;
  logic              stepLast;

  assign accept = (state == ST_IDLE) && Start;

  // Loaded with Steps when a command is accepted; LOAD leaves it untouched.
  step_counter #(
    .STEPW(STEPW)
  ) u_step_counter (
    .CLOCK    (CLOCK),
    .Reset    (Reset),
    .Load     (accept),
    .LoadValue(Steps),
    .Dec      (state == ST_RUN),
    .Zero     (stepZero),
    .Last     (stepLast)
  );

  always_comb begin
    stateNext   = state;
    dirNext     = dirReg;
    pNext       = P;
    abortedNext = Aborted;
    wrapNext    = WrapCount;
    modeNext    = MODE_HOLD;
    busyNext    = 1'b0;
    doneNext    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (Start) begin
          dirNext     = Dir;
          abortedNext = 1'b0;
          wrapNext    = '0;
          if (LoadEn) begin
            stateNext = ST_LOAD;
            pNext     = LoadValue;
          end else if (Steps != '0) begin
            stateNext = ST_RUN;
          end else begin
            stateNext = ST_DONE;
          end
        end
      end
      ST_LOAD: begin
        if (Abort) begin
          stateNext   = ST_DONE;
          abortedNext = 1'b1;
        end else if (stepZero) begin
          stateNext = ST_DONE;
        end else begin
          stateNext = ST_RUN;
        end
      end
      ST_RUN: begin
        if (TerminalCount && (WrapCount != WRAP_MAX)) begin
          wrapNext = WrapCount + 1'b1;
        end
        if (Abort) begin
          stateNext   = ST_DONE;
          abortedNext = 1'b1;
        end else if (stepLast) begin
          stateNext = ST_DONE;
        end
      end
      ST_DONE: stateNext = ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase

    // Outputs are decoded from the upcoming state so they register alongside it.
    case (stateNext)
      ST_LOAD: begin
        modeNext = MODE_LOAD;
        busyNext = 1'b1;
      end
      ST_RUN: begin
        modeNext = run_mode(dirNext);
        busyNext = 1'b1;
      end
      ST_DONE: doneNext = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      state     <= ST_IDLE;
      dirReg    <= 1'b0;
      {S1, S0}  <= MODE_HOLD;
      P         <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Aborted   <= 1'b0;
      WrapCount <= '0;
    end else begin
      state     <= stateNext;
      dirReg    <= dirNext;
      {S1, S0}  <= modeNext;
      P         <= pNext;
      Busy      <= busyNext;
      Done      <= doneNext;
      Aborted   <= abortedNext;
      WrapCount <= wrapNext;
    end
  end

endmodule

// File: tb/tb_counter_mode_sequencer.sv
// Bench pairing the sequencer with a behavioural universal counter (BeginCount 0)
// and checking each command against a per-command reference prediction.
module tb_counter_mode_sequencer;
  import counter_mode_sequencer_pkg::*;

  localparam int LENGTH = 4;
  localparam int STEPW  = 8;
  localparam logic [LENGTH-1:0] BEGIN_COUNT = '0;

  logic              CLOCK = 1'b0;
  logic              Reset;
  logic              Start;
  logic              Dir;
  logic              LoadEn;
  logic [LENGTH-1:0] LoadValue;
  logic [STEPW-1:0]  Steps;
  logic              Abort;
  logic              TerminalCount;
  logic              S1;
  logic              S0;
  logic [LENGTH-1:0] P;
  logic              Busy;
  logic              Done;
  logic              Aborted;
  logic [STEPW-1:0]  WrapCount;

  logic [LENGTH-1:0] counterValue = '0;
  logic [LENGTH-1:0] endCount = 4'd9;
  logic [LENGTH-1:0] expP = '0;
  int vectors = 0;
  int miscompares = 0;

  counter_mode_sequencer #(.LENGTH(LENGTH), .STEPW(STEPW)) dut (
    .CLOCK(CLOCK), .Reset(Reset), .Start(Start), .Dir(Dir), .LoadEn(LoadEn),
    .LoadValue(LoadValue), .Steps(Steps), .Abort(Abort), .TerminalCount(TerminalCount),
    .S1(S1), .S0(S0), .P(P), .Busy(Busy), .Done(Done), .Aborted(Aborted), .WrapCount(WrapCount)
  );

  always #5 CLOCK = ~CLOCK;

  // Universal counter driven by the sequencer's mode select.
  always @(posedge CLOCK) begin
    case ({S1, S0})
      MODE_UP:   counterValue <= (counterValue == endCount) ? BEGIN_COUNT : LENGTH'(counterValue + 4'd1);
      MODE_DOWN: counterValue <= (counterValue == BEGIN_COUNT) ? endCount : LENGTH'(counterValue - 4'd1);
      MODE_LOAD: counterValue <= P;
      default: ;
    endcase
  end

  assign TerminalCount = (({S1, S0} == MODE_UP) && (counterValue == endCount)) ||
                         (({S1, S0} == MODE_DOWN) && (counterValue == BEGIN_COUNT));

  // One command: predict mode sequence, wrap count, abort flag and final counter, then observe.
  task automatic run_command(input string name, input logic dir, input logic loadEn,
                             input logic [LENGTH-1:0] loadValue, input int steps,
                             input int abortAt, input logic abortInLoad, input logic noise);
    logic [1:0] expMode[$];
    int runCycles;
    int tcEvents;
    int abortCycle;
    logic [LENGTH-1:0] v;
    logic expAborted;
    logic [STEPW-1:0] expWrap;

    v = loadEn ? loadValue : counterValue;
    if (loadEn) expP = loadValue;
    expAborted = 1'b0;
    abortCycle = -1;
    if (loadEn) expMode.push_back(MODE_LOAD);
    if (loadEn && abortInLoad) begin
      runCycles = 0; expAborted = 1'b1; abortCycle = 0;
    end else if (abortAt >= 1 && abortAt <= steps) begin
      runCycles = abortAt; expAborted = 1'b1; abortCycle = int'(loadEn) + abortAt - 1;
    end else begin
      runCycles = steps;
    end
    tcEvents = 0;
    for (int k = 0; k < runCycles; k++) begin
      expMode.push_back(dir ? MODE_DOWN : MODE_UP);
      if (!dir) begin
        if (v == endCount) begin tcEvents++; v = BEGIN_COUNT; end else v = v + 4'd1;
      end else begin
        if (v == BEGIN_COUNT) begin tcEvents++; v = endCount; end else v = v - 4'd1;
      end
    end
    expWrap = (tcEvents > 255) ? 8'd255 : STEPW'(tcEvents);

    Start = 1'b1; Dir = dir; LoadEn = loadEn; LoadValue = loadValue; Steps = STEPW'(steps);
    Abort = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    @(posedge CLOCK); #1;
    Start = 1'b0; Abort = 1'b0;

    for (int i = 0; i < expMode.size(); i++) begin
      vectors++;
      if ({S1, S0} !== expMode[i]) begin
        miscompares++;
        $display("[TB] FAIL %s mode cycle %0d: got %b expected %b", name, i, {S1, S0}, expMode[i]);
      end
      vectors++;
      if (Busy !== 1'b1 || Done !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL %s busy/done cycle %0d: got %b%b expected 10", name, i, Busy, Done);
      end
      Abort = (i == abortCycle);
      if (noise) begin
        Start = 1'($urandom_range(0, 1)); Dir = 1'($urandom_range(0, 1));
        LoadEn = 1'($urandom_range(0, 1)); LoadValue = LENGTH'($urandom_range(0, 9));
        Steps = STEPW'($urandom_range(0, 255));
      end
      @(posedge CLOCK); #1;
      Abort = 1'b0;
    end

    vectors++;
    if ({S1, S0, Busy, Done} !== {MODE_HOLD, 2'b01}) begin
      miscompares++;
      $display("[TB] FAIL %s done cycle mode/busy/done: got %b expected 0001", name, {S1, S0, Busy, Done});
    end
    vectors++;
    if (Aborted !== expAborted) begin
      miscompares++;
      $display("[TB] FAIL %s aborted: got %b expected %b", name, Aborted, expAborted);
    end
    vectors++;
    if (WrapCount !== expWrap) begin
      miscompares++;
      $display("[TB] FAIL %s wrapcount: got %0d expected %0d", name, WrapCount, expWrap);
    end
    Start = noise; Abort = noise;
    @(posedge CLOCK); #1;
    Start = 1'b0; Abort = 1'b0;

    vectors++;
    if ({S1, S0, Busy, Done} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL %s idle mode/busy/done: got %b expected 0000", name, {S1, S0, Busy, Done});
    end
    vectors++;
    if (Aborted !== expAborted || WrapCount !== expWrap) begin
      miscompares++;
      $display("[TB] FAIL %s idle hold: got %b/%0d expected %b/%0d", name, Aborted, WrapCount, expAborted, expWrap);
    end
    vectors++;
    if (P !== expP) begin
      miscompares++;
      $display("[TB] FAIL %s P: got %0d expected %0d", name, P, expP);
    end
    vectors++;
    if (counterValue !== v) begin
      miscompares++;
      $display("[TB] FAIL %s counter: got %0d expected %0d", name, counterValue, v);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0; Dir = 1'b0; LoadEn = 1'b0; LoadValue = '0; Steps = '0; Abort = 1'b0;
    repeat (2) @(posedge CLOCK);
    #1;
    vectors++;
    if ({S1, S0, P, Busy, Done, Aborted, WrapCount} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset outputs: got %b expected all zero", {S1, S0, P, Busy, Done, Aborted, WrapCount});
    end
    Reset = 1'b0;
    expP = '0;
  endtask

  task automatic test_directed();
    run_command("load_up_5", 1'b0, 1'b1, 4'd7, 5, 0, 1'b0, 1'b0);
    run_command("load_1_no_steps", 1'b0, 1'b1, 4'd1, 0, 0, 1'b0, 1'b0);
    run_command("down_3", 1'b1, 1'b0, 4'd0, 3, 0, 1'b0, 1'b0);
    run_command("zero_steps", 1'b0, 1'b0, 4'd0, 0, 0, 1'b0, 1'b0);
    run_command("abort_run2", 1'b0, 1'b0, 4'd0, 10, 2, 1'b0, 1'b0);
    run_command("abort_last_step", 1'b1, 1'b1, 4'd4, 3, 3, 1'b0, 1'b0);
    run_command("abort_in_load", 1'b0, 1'b1, 4'd5, 6, 0, 1'b1, 1'b0);
    run_command("start_in_done", 1'b0, 1'b1, 4'd9, 1, 0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    Start = 1'b1; Dir = 1'b0; LoadEn = 1'b0; Steps = 8'd10;
    @(posedge CLOCK); #1;
    Start = 1'b0;
    repeat (2) begin @(posedge CLOCK); #1; end
    vectors++;
    if (Busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_run busy before reset: got %b expected 1", Busy);
    end
    Reset = 1'b1; Start = 1'b1; Abort = 1'b1;
    @(posedge CLOCK); #1;
    vectors++;
    if ({S1, S0, P, Busy, Done, Aborted, WrapCount} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_run outputs: got %b expected all zero", {S1, S0, P, Busy, Done, Aborted, WrapCount});
    end
    LoadEn = 1'b1; LoadValue = 4'd6;
    @(posedge CLOCK); #1;
    vectors++;
    if ({S1, S0, P, Busy, Done} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_priority outputs: got %b expected all zero", {S1, S0, P, Busy, Done});
    end
    Reset = 1'b0; Start = 1'b0; Abort = 1'b0;
    @(posedge CLOCK); #1;
    vectors++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_release idle: got %b%b expected 00", Busy, Done);
    end
    expP = '0;
  endtask

  task automatic test_saturate();
    endCount = 4'd0;
    run_command("saturate_255", 1'b0, 1'b1, 4'd0, 255, 0, 1'b0, 1'b0);
    endCount = 4'd9;
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      int steps;
      int abortAt;
      steps = $urandom_range(0, 20);
      abortAt = ($urandom_range(0, 2) == 0) ? $urandom_range(1, steps + 2) : 0;
      run_command("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  LENGTH'($urandom_range(0, 9)), steps, abortAt,
                  1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid_run();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/counter_mode_sequencer.md
COUNTER_MODE_SEQUENCER -- requirements
Module: counter_mode_sequencer

Interface
REQ-001 Parameter LENGTH, default 4, width of the counter data path driven on P.
REQ-002 Parameter STEPW, default 8, width of Steps and WrapCount.
REQ-003 CLOCK  input  1  single clock; all state changes on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset, sampled on the rising edge of CLOCK.
REQ-005 Start  input  1  request to begin a command; sampled only in IDLE.
REQ-006 Dir  input  1  run direction, 0 = up, 1 = down; captured with Start.
REQ-007 LoadEn  input  1  1 = parallel-load LoadValue before running; captured with Start.
REQ-008 LoadValue  input  LENGTH  value to load; captured with Start.
REQ-009 Steps  input  STEPW  number of count cycles; captured with Start.
REQ-010 Abort  input  1  terminate the current command early.
REQ-011 TerminalCount  input  1  terminal-count flag returned by the driven counter.
REQ-012 S1, S0  output  1 each  counter mode select: 00 hold, 01 up, 10 down, 11 load.
REQ-013 P  output  LENGTH  parallel-load data to the counter.
REQ-014 Busy  output  1  high in LOAD and RUN.
REQ-015 Done  output  1  one-cycle completion pulse.
REQ-016 Aborted  output  1  high with Done when the command ended via Abort.
REQ-017 WrapCount  output  STEPW  number of TerminalCount events seen during RUN.

Function
REQ-018 The FSM SHALL have the states IDLE, LOAD, RUN and DONE; all outputs SHALL be registered and decoded from state, with no combinational path from any input to any output.
REQ-019 In IDLE: {S1,S0}=00, Busy=0, Done=0; on Start=1 the block SHALL capture Dir, LoadEn, LoadValue and Steps, clear WrapCount to 0, and go to LOAD if LoadEn=1, else to RUN if Steps!=0, else to DONE.
REQ-020 LOAD SHALL last exactly one cycle with {S1,S0}=11 and P=captured LoadValue, then go to RUN if Steps!=0, else to DONE.
REQ-021 RUN SHALL last exactly Steps cycles, driving {S1,S0}=01 if Dir=0 or 10 if Dir=1, with an internal step counter decrementing once per cycle; it SHALL go to DONE after the last step.
REQ-022 In each RUN cycle where TerminalCount=1, WrapCount SHALL increment at that edge and saturate at 2^STEPW-1.
REQ-023 DONE SHALL last exactly one cycle with {S1,S0}=00, Done=1 and Busy=0, then return to IDLE; Aborted and WrapCount SHALL hold until the next accepted Start.
REQ-024 Abort=1 sampled in LOAD or RUN SHALL force the next state to DONE with Aborted=1; Abort in IDLE or DONE SHALL be ignored.
REQ-025 If Abort and the last RUN step coincide, Aborted SHALL be 1.
REQ-026 Start SHALL be ignored outside IDLE, including in the DONE cycle; commands SHALL NOT queue.
REQ-027 P SHALL hold its last loaded value outside LOAD.
REQ-028 Latency: the first mode cycle SHALL be the cycle after Start is sampled; the total Busy time SHALL be LoadEn+Steps cycles.

Reset
REQ-029 Reset=1 at a rising edge SHALL, from any state including mid-command, set: state IDLE, {S1,S0}=00, P=0, Busy=0, Done=0, Aborted=0, WrapCount=0, step counter=0.
REQ-030 Reset SHALL take priority over Start and Abort.

Structure
REQ-031 The state encoding and the mode constants HOLD=00, UP=01, DOWN=10, LOAD=11 SHALL live in a shared package that the counter benches also use.
REQ-032 The step down-counter SHALL be a sub-module named step_counter (load, decrement, zero flag); the FSM and the registered output logic SHALL stay in counter_mode_sequencer.

Verification (bench pairs the block with the universal counter, LENGTH=4, EndCount=9, BeginCount=0)
REQ-033 Start with LoadEn=1, LoadValue=7, Dir=0, Steps=5 -> one cycle of 11, five cycles of 01, counter 7,8,9,0,1,2, WrapCount=1, then one Done pulse.
REQ-034 Start with LoadEn=0, Dir=1, Steps=3, counter at 1 -> three cycles of 10, counter 0,9,8, WrapCount=1, Busy high for 3 cycles.
REQ-035 Start with LoadEn=0, Steps=0 -> DONE in the next cycle, Busy never high, WrapCount=0.
REQ-036 Abort during the 2nd RUN cycle of Steps=10 -> DONE with Aborted=1 on the next cycle; the counter has advanced exactly 2.
REQ-037 Reset asserted during the 3rd RUN cycle -> all outputs at reset values on the next cycle; Start asserted during DONE -> ignored.
REQ-038 Steps=255, Dir=0, EndCount=0 so that TerminalCount is high every cycle -> WrapCount saturates at 255 without wrapping.
